// File: rtl/bus_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_mem_slave                                                |
// | Description : Pipelined bus responder backed by a word-addressed flop RAM, |
// |               with wait states and a two-cycle error response.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module bus_mem_slave #(
    parameter int DEPTH      = 256,
    parameter int WAITSTATES = 0
) (
    input  logic        main_clk_i,
    input  logic        main_rst_an_i,
    input  logic [1:0]  bus_trans_i,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_write_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ready_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_o
);

    localparam int                 C_IDX_W       = $clog2(DEPTH);
    localparam int                 C_CNT_W       = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_WAIT_LOAD   = C_CNT_W'(WAITSTATES);
    localparam logic [29:0]        C_DEPTH_WORDS = 30'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_write;
    logic               r_ready;
    logic               r_resp;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_err;
    logic               w_store;
    logic [C_IDX_W-1:0] w_idx;
    logic [31:0]        w_fwd_rdata;

    assign w_accept = r_ready && ((bus_trans_i == 2'd2) || (bus_trans_i == 2'd3));
    assign w_err    = (bus_addr_i[1:0] != 2'b00) || (bus_addr_i[31:2] >= C_DEPTH_WORDS);
    assign w_idx    = bus_addr_i[2 +: C_IDX_W];
    assign w_store  = (r_state == S_DATA) && r_write;

    // A write finishing this cycle lands on the same edge that loads the next read, so bypass it.
    assign w_fwd_rdata = (w_store && (r_idx == w_idx)) ? bus_wdata_i : r_mem[w_idx];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_word
            always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
                if (!main_rst_an_i) begin
                    r_mem[g] <= '0;
                end else if (w_store && (r_idx == C_IDX_W'(g))) begin
                    r_mem[g] <= bus_wdata_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - C_CNT_W'(1);
                    if (r_cnt == C_CNT_W'(1)) begin
                        r_state <= S_DATA;
                        r_ready <= 1'b1;
                        r_resp  <= 1'b0;
                        r_rdata <= r_write ? 32'h0 : r_mem[r_idx];
                    end
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                    r_ready <= 1'b1;
                    r_resp  <= 1'b1;
                    r_rdata <= '0;
                end
                default: begin
                    if (!w_accept) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_resp  <= 1'b0;
                        r_rdata <= '0;
                    end else begin
                        r_idx   <= w_idx;
                        r_write <= bus_write_i;
                        if (w_err) begin
                            r_state <= S_ERR1;
                            r_ready <= 1'b0;
                            r_resp  <= 1'b1;
                            r_rdata <= '0;
                        end else if (WAITSTATES == 0) begin
                            r_state <= S_DATA;
                            r_ready <= 1'b1;
                            r_resp  <= 1'b0;
                            r_rdata <= bus_write_i ? 32'h0 : w_fwd_rdata;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= C_WAIT_LOAD;
                            r_ready <= 1'b0;
                            r_resp  <= 1'b0;
                            r_rdata <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus_ready_o = r_ready;
    assign bus_resp_o  = r_resp;
    assign bus_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_mem_slave                                             |
// | Description : Scoreboard bench driving three bus_mem_slave instances       |
// |               (0, 2 and 3 wait states) through directed and random traffic.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_bus_mem_slave;

    localparam int C_DEPTH = 256;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  trans [3];
    logic [31:0] addr  [3];
    logic        write [3];
    logic [31:0] wdata [3];
    logic        ready [3];
    logic        resp  [3];
    logic [31:0] rdata [3];

    int          ws [3];
    logic [31:0] mem_m [3][C_DEPTH];
    req_t        reqs [$];
    exp_t        sb [$];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    bus_mem_slave #(.DEPTH(C_DEPTH), .WAITSTATES(0)) u_ws0 (
        .main_clk_i(clk), .main_rst_an_i(rst_n),
        .bus_trans_i(trans[0]), .bus_addr_i(addr[0]), .bus_write_i(write[0]),
        .bus_wdata_i(wdata[0]), .bus_ready_o(ready[0]), .bus_resp_o(resp[0]),
        .bus_rdata_o(rdata[0])
    );

    bus_mem_slave #(.DEPTH(C_DEPTH), .WAITSTATES(2)) u_ws2 (
        .main_clk_i(clk), .main_rst_an_i(rst_n),
        .bus_trans_i(trans[1]), .bus_addr_i(addr[1]), .bus_write_i(write[1]),
        .bus_wdata_i(wdata[1]), .bus_ready_o(ready[1]), .bus_resp_o(resp[1]),
        .bus_rdata_o(rdata[1])
    );

    bus_mem_slave #(.DEPTH(C_DEPTH), .WAITSTATES(3)) u_ws3 (
        .main_clk_i(clk), .main_rst_an_i(rst_n),
        .bus_trans_i(trans[2]), .bus_addr_i(addr[2]), .bus_write_i(write[2]),
        .bus_wdata_i(wdata[2]), .bus_ready_o(ready[2]), .bus_resp_o(resp[2]),
        .bus_rdata_o(rdata[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
        req_t q;
        q.trans = t;
        q.addr  = a;
        q.write = w;
        q.wdata = d;
        reqs.push_back(q);
    endtask

    function automatic req_t next_req();
        req_t q;
        q.trans = 2'd0;
        q.addr  = 32'h0;
        q.write = 1'b0;
        q.wdata = 32'h0;
        if (reqs.size() != 0) q = reqs.pop_front();
        return q;
    endfunction

    // Reference view: errors and read data come from the bench's own memory model.
    function automatic exp_t expect_of(input int s, input req_t q);
        exp_t e;
        e.err   = (q.addr[1:0] != 2'b00) || (q.addr[31:10] != 22'h0);
        e.rdata = (e.err || q.write) ? 32'h0 : mem_m[s][q.addr[9:2]];
        return e;
    endfunction

    // Plays the queued requests into instance s; entered and left at posedge+1.
    task automatic run(input int s);
        req_t        pres;
        req_t        cur;
        exp_t        e;
        logic        cur_v;
        logic        r;
        logic        p;
        logic [31:0] d;
        int          waits;
        int          cycles;
        cur_v  = 1'b0;
        waits  = 0;
        cycles = 0;
        cur    = next_req();
        pres   = next_req();
        if (pres.trans == 2'd0 && reqs.size() == 0) reqs.push_front(pres);
        forever begin
            r = ready[s];
            p = resp[s];
            d = rdata[s];
            if (cur_v) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
                    break;
                end
                e = sb[0];
                if (!r) begin
                    waits++;
                    check("stall_phase", {p, d}, {e.err, 32'h0});
                end else begin
                    e = sb.pop_front();
                    check("resp", p, e.err);
                    check("rdata", d, e.rdata);
                    check("stall_cycles", waits, e.err ? 1 : ws[s]);
                    if (cur.write && !e.err) mem_m[s][cur.addr[9:2]] = cur.wdata;
                end
            end else begin
                check("idle_phase", {r, p, d}, {1'b1, 1'b0, 32'h0});
            end
            wdata[s] = (cur_v && cur.write) ? cur.wdata : $urandom();
            trans[s] = pres.trans;
            addr[s]  = pres.addr;
            write[s] = pres.write;
            if (r) begin
                if (pres.trans[1]) sb.push_back(expect_of(s, pres));
                cur   = pres;
                cur_v = pres.trans[1];
                waits = 0;
                if (!cur_v && reqs.size() == 0) begin
                    @(posedge clk); #1;
                    break;
                end
                pres = next_req();
            end
            cycles++;
            if (cycles > 20000) begin
                miscompares++;
                $error("FAIL run_timeout: observed %0d cycles expected completion", cycles);
                break;
            end
            @(posedge clk); #1;
        end
        trans[s] = 2'd0;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int          k;
        logic [31:0] a;
        logic [1:0]  t;

        ws[0] = 0;
        ws[1] = 2;
        ws[2] = 3;
        for (int s = 0; s < 3; s++) begin
            trans[s] = 2'd0;
            addr[s]  = 32'h0;
            write[s] = 1'b0;
            wdata[s] = 32'h0;
            for (int i = 0; i < C_DEPTH; i++) mem_m[s][i] = 32'h0;
        end

        rst_n = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) check("in_reset", {ready[s], resp[s], rdata[s]}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 3; s++) check("reset_idle", {ready[s], resp[s], rdata[s]}, {1'b1, 1'b0, 32'h0});
            @(posedge clk); #1;
        end

        // Reset in the middle of a write's wait phase: outputs recover at once and the write is dropped.
        trans[2] = 2'd2;
        addr[2]  = 32'h20;
        write[2] = 1'b1;
        @(posedge clk); #1;
        trans[2] = 2'd0;
        wdata[2] = 32'hCAFE0001;
        check("ws3_wait1", ready[2], 1'b0);
        @(posedge clk); #1;
        check("ws3_wait2", ready[2], 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {ready[2], resp[2], rdata[2]}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req(2'd2, 32'h20, 1'b0, 32'h0);
        req(2'd2, 32'h24, 1'b1, 32'h0BADF00D);
        req(2'd2, 32'h24, 1'b0, 32'h0);
        run(2);

        req(2'd2, 32'h10, 1'b1, 32'hDEADBEEF);
        req(2'd2, 32'h10, 1'b0, 32'h0);
        req(2'd2, 32'h0,  1'b0, 32'h0);
        req(2'd3, 32'h4,  1'b0, 32'h0);
        req(2'd3, 32'h8,  1'b0, 32'h0);
        req(2'd2, 32'h13, 1'b1, 32'hFFFFFFFF);
        req(2'd2, 32'h10, 1'b0, 32'h0);
        req(2'd2, 32'h400, 1'b0, 32'h0);
        req(2'd2, 32'h3FC, 1'b1, 32'hA5A5A5A5);
        req(2'd2, 32'h3FC, 1'b0, 32'h0);
        run(0);

        req(2'd2, 32'h10, 1'b1, 32'h12345678);
        req(2'd2, 32'h10, 1'b0, 32'h0);
        req(2'd1, 32'h10, 1'b1, 32'h0);
        req(2'd0, 32'h14, 1'b1, 32'h0);
        req(2'd2, 32'h13, 1'b1, 32'hFFFFFFFF);
        req(2'd2, 32'h10, 1'b0, 32'h0);
        req(2'd2, 32'h400, 1'b0, 32'h0);
        req(2'd2, 32'h3FC, 1'b0, 32'h0);
        run(1);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < (s == 0 ? 1000 : 300); i++) begin
                k = $urandom_range(0, 9);
                case (k)
                    0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15)) << 2;
                    6:                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                    7:                a = 32'h400 + (32'($urandom_range(0, 63)) << 2);
                    8:                a = $urandom();
                    default:          a = 32'h3FC;
                endcase
                k = $urandom_range(0, 7);
                t = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 5) ? 2'd2 : 2'd3;
                req(t, a, 1'($urandom_range(0, 1)), $urandom());
            end
            run(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
